// File: rtl/display_channel_scheduler_if.sv
// rtl/display_channel_scheduler_if.sv - channel samples, user controls and display-side outputs
interface display_channel_scheduler_if;
    logic [15:0] ch0_data;
    logic        ch0_valid;
    logic [15:0] ch1_data;
    logic        ch1_valid;
    logic [15:0] ch2_data;
    logic        ch2_valid;
    logic        mode_auto;
    logic        next_req;
    logic        freeze;
    logic [15:0] num;
    logic [1:0]  chan_sel;
    logic [2:0]  chan_leds;
    logic        num_update;

    modport master (
        output ch0_data, ch0_valid, ch1_data, ch1_valid, ch2_data, ch2_valid,
        output mode_auto, next_req, freeze,
        input  num, chan_sel, chan_leds, num_update
    );

    modport slave (
        input  ch0_data, ch0_valid, ch1_data, ch1_valid, ch2_data, ch2_valid,
        input  mode_auto, next_req, freeze,
        output num, chan_sel, chan_leds, num_update
    );
endinterface

// File: rtl/display_channel_scheduler.sv
// rtl/display_channel_scheduler.sv - rotates three shadowed sample channels onto one hex display
module display_channel_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int DWELL_MS = 2000
) (
    input  logic                         clk,
    input  logic                         rst,
    display_channel_scheduler_if.slave   bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_MS - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_SHOW, ST_FROZEN} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc;
    logic [DW-1:0]  dwell, dwell_nxt;
    logic [15:0]    sh0, sh1, sh2;
    logic [2:0]     seen;
    logic [15:0]    num_q, num_nxt;
    logic [1:0]     sel_q, sel_nxt;
    logic [2:0]     leds_q, leds_nxt;
    logic           upd_q;

    logic [2:0]     valid_v, seen_now;
    logic           tick, expire, advance;
    logic [1:0]     inc1, inc2, adv_idx;

    function automatic logic [15:0] pick(input logic [1:0] idx, input logic [2:0] v,
                                         input logic [15:0] d0, input logic [15:0] d1,
                                         input logic [15:0] d2, input logic [15:0] s0,
                                         input logic [15:0] s1, input logic [15:0] s2);
        case (idx)
            2'd0:    pick = v[0] ? d0 : s0;
            2'd1:    pick = v[1] ? d1 : s1;
            default: pick = v[2] ? d2 : s2;
        endcase
    endfunction

    assign valid_v  = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
    assign seen_now = seen | valid_v;
    assign tick     = (presc == PRESC_MAX);
    assign expire   = tick && (dwell == DWELL_MAX) && bus.mode_auto && (state == ST_SHOW);
    assign advance  = (state == ST_SHOW) && !bus.freeze && (bus.next_req || expire);

    // Search forward from the displayed channel, skipping channels never sampled.
    assign inc1    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    assign inc2    = (inc1 == 2'd2) ? 2'd0 : inc1 + 2'd1;
    assign adv_idx = seen_now[inc1] ? inc1 : (seen_now[inc2] ? inc2 : sel_q);

    always_comb begin
        state_nxt = state;
        num_nxt   = num_q;
        sel_nxt   = sel_q;
        dwell_nxt = dwell;
        case (state)
            ST_WAIT: begin
                dwell_nxt = '0;
                if (|valid_v) begin
                    state_nxt = ST_SHOW;
                    sel_nxt   = valid_v[0] ? 2'd0 : (valid_v[1] ? 2'd1 : 2'd2);
                    num_nxt   = pick(sel_nxt, valid_v, bus.ch0_data, bus.ch1_data, bus.ch2_data, sh0, sh1, sh2);
                end
            end
            ST_SHOW: begin
                if (bus.freeze) begin
                    state_nxt = ST_FROZEN;
                end else begin
                    if (advance) begin
                        sel_nxt   = adv_idx;
                        dwell_nxt = '0;
                    end else if (!bus.mode_auto) begin
                        dwell_nxt = '0;
                    end else if (tick) begin
                        dwell_nxt = dwell + 1'b1;
                    end
                    num_nxt = pick(sel_nxt, valid_v, bus.ch0_data, bus.ch1_data, bus.ch2_data, sh0, sh1, sh2);
                end
            end
            ST_FROZEN: begin
                if (!bus.freeze) begin
                    state_nxt = ST_SHOW;
                    dwell_nxt = '0;
                    num_nxt   = pick(sel_q, valid_v, bus.ch0_data, bus.ch1_data, bus.ch2_data, sh0, sh1, sh2);
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
        leds_nxt = (state_nxt == ST_WAIT) ? 3'b000 : (3'b001 << sel_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_WAIT;
            presc  <= '0;
            dwell  <= '0;
            sh0    <= '0;
            sh1    <= '0;
            sh2    <= '0;
            seen   <= '0;
            num_q  <= '0;
            sel_q  <= '0;
            leds_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            presc  <= tick ? '0 : presc + 1'b1;
            dwell  <= dwell_nxt;
            if (bus.ch0_valid) sh0 <= bus.ch0_data;
            if (bus.ch1_valid) sh1 <= bus.ch1_data;
            if (bus.ch2_valid) sh2 <= bus.ch2_data;
            seen   <= seen_now;
            num_q  <= num_nxt;
            sel_q  <= sel_nxt;
            leds_q <= leds_nxt;
            upd_q  <= (num_nxt != num_q) || (sel_nxt != sel_q);
        end
    end

    assign bus.num        = num_q;
    assign bus.chan_sel   = sel_q;
    assign bus.chan_leds  = leds_q;
    assign bus.num_update = upd_q;
endmodule

// File: tb/tb_display_channel_scheduler.sv
// tb/tb_display_channel_scheduler.sv - scoreboard bench: stimulus queues expected display updates, monitor checks them
module tb_display_channel_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   last_upd_cyc;

    display_channel_scheduler_if bus();

    display_channel_scheduler #(.TICK_DIV(4), .DWELL_MS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] num;
        logic [1:0]  sel;
        logic [2:0]  leds;
        int          gap;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [15:0] n, input logic [1:0] s, input logic [2:0] l, input int gap);
        exp_t e;
        e.num = n; e.sel = s; e.leds = l; e.gap = gap;
        q.push_back(e);
    endtask

    // Monitor: every num_update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.num_update === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_update", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("upd_num", int'(bus.num), int'(e.num));
                check("upd_sel", int'(bus.chan_sel), int'(e.sel));
                check("upd_leds", int'(bus.chan_leds), int'(e.leds));
                if (e.gap != 0) check("upd_gap", cyc - last_upd_cyc, e.gap);
            end
            last_upd_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            check({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_num", int'(bus.num), 0);
        check("rst_sel", int'(bus.chan_sel), 0);
        check("rst_leds", int'(bus.chan_leds), 0);
        check("rst_upd", int'(bus.num_update), 0);
        rst = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next_req = 1'b1;
        step();
        bus.next_req = 1'b0;
    endtask

    int e0;

    initial begin
        cyc = 0;
        last_upd_cyc = 0;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.ch0_data = '0; bus.ch0_valid = 1'b0;
        bus.ch1_data = '0; bus.ch1_valid = 1'b0;
        bus.ch2_data = '0; bus.ch2_valid = 1'b0;
        bus.mode_auto = 1'b0;
        bus.next_req  = 1'b0;
        bus.freeze    = 1'b0;
        step();
        step();
        do_reset();

        // Idle in WAIT: display stays blank and silent.
        repeat (100) step();
        check("idle_num", int'(bus.num), 0);
        check("idle_leds", int'(bus.chan_leds), 0);

        // First sample on ch1 with a negative value.
        push(16'hFF85, 2'd1, 3'b010, 0);
        bus.ch1_data = 16'hFF85; bus.ch1_valid = 1'b1;
        step();
        bus.ch1_valid = 1'b0;
        drain("first_sample", 5);

        // Auto rotation across all three channels, 12 cycles per channel.
        do_reset();
        bus.mode_auto = 1'b1;
        push(16'h0001, 2'd0, 3'b001, 0);
        push(16'h0002, 2'd1, 3'b010, 0);
        push(16'h0003, 2'd2, 3'b100, 12);
        push(16'h0001, 2'd0, 3'b001, 12);
        push(16'h0002, 2'd1, 3'b010, 12);
        bus.ch0_data = 16'h0001; bus.ch1_data = 16'h0002; bus.ch2_data = 16'h0003;
        bus.ch0_valid = 1'b1; bus.ch1_valid = 1'b1; bus.ch2_valid = 1'b1;
        step();
        bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0; bus.ch2_valid = 1'b0;
        drain("auto_rotate", 100);

        // Reset mid-rotation, then stay in WAIT despite auto mode.
        do_reset();
        repeat (30) step();
        check("post_rst_leds", int'(bus.chan_leds), 0);
        bus.mode_auto = 1'b0;

        // Only ch0 and ch2 seen: manual advances skip ch1.
        push(16'h0A00, 2'd0, 3'b001, 0);
        bus.ch0_data = 16'h0A00; bus.ch2_data = 16'h0C00;
        bus.ch0_valid = 1'b1; bus.ch2_valid = 1'b1;
        step();
        bus.ch0_valid = 1'b0; bus.ch2_valid = 1'b0;
        drain("two_ch_start", 5);
        push(16'h0C00, 2'd2, 3'b100, 0);
        pulse_next();
        drain("next_0_2", 5);
        push(16'h0A00, 2'd0, 3'b001, 0);
        pulse_next();
        drain("next_2_0", 5);

        // next_req coinciding with expiry gives exactly one advance.
        bus.mode_auto = 1'b1;
        push(16'h0C00, 2'd2, 3'b100, 0);
        drain("auto_two_ch", 40);
        e0 = last_upd_cyc;
        push(16'h0A00, 2'd0, 3'b001, 12);
        begin
            int n;
            n = 0;
            while (cyc < e0 + 11 && n < 40) begin
                step();
                n++;
            end
            check("align_expire", cyc, e0 + 11);
        end
        bus.next_req = 1'b1;
        step();
        bus.next_req = 1'b0;
        bus.mode_auto = 1'b0;
        drain("next_on_expire", 5);
        repeat (20) step();

        // Freeze: new samples and next_req must not disturb the display.
        bus.freeze = 1'b1;
        step();
        bus.ch0_data = 16'h1111; bus.ch0_valid = 1'b1;
        bus.ch2_data = 16'h2222; bus.ch2_valid = 1'b1;
        bus.next_req = 1'b1;
        step();
        bus.ch0_valid = 1'b0; bus.ch2_valid = 1'b0; bus.next_req = 1'b0;
        repeat (5) step();
        pulse_next();
        repeat (3) step();
        check("frozen_num", int'(bus.num), 16'h0A00);
        check("frozen_sel", int'(bus.chan_sel), 0);
        check("frozen_leds", int'(bus.chan_leds), 3'b001);
        push(16'h1111, 2'd0, 3'b001, 0);
        bus.freeze = 1'b0;
        step();
        check("unfreeze_num", int'(bus.num), 16'h1111);
        drain("unfreeze", 5);
        repeat (10) step();

        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
